// File: rtl/bit_serializer.sv
// bit_serializer: parallel words in over valid/ready, MSB-first serial bits out.
// Define BIT_SERIALIZER_PARITY_EN to append an even-parity bit after each word.
module bit_serializer #(
    parameter int   WIDTH      = 8,
    parameter int   CNT_W      = 3,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             word_done
);

`ifdef BIT_SERIALIZER_PARITY_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;
`else
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;
`endif

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-2:0] shreg;
    logic [CNT_W-1:0] cnt;
    logic             last_bit;
    logic             accept;
`ifdef BIT_SERIALIZER_PARITY_EN
    logic             par;
`endif

    assign last_bit = (state == SHIFT) && (cnt == LAST);

`ifdef BIT_SERIALIZER_PARITY_EN
    assign load_ready = (state == IDLE) || (state == PARITY);
`else
    assign load_ready = (state == IDLE) || last_bit;
`endif

    assign accept = load_valid && load_ready;

    // MSB goes straight to ser_out; shreg keeps only the bits still to come.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            shreg     <= '0;
            cnt       <= '0;
            ser_out   <= IDLE_LEVEL;
            ser_valid <= 1'b0;
            word_done <= 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
            par       <= 1'b0;
`endif
        end else begin
            word_done <= 1'b0;
            if (accept) begin
                state     <= SHIFT;
                shreg     <= data_in[WIDTH-2:0];
                cnt       <= '0;
                ser_out   <= data_in[WIDTH-1];
                ser_valid <= 1'b1;
`ifdef BIT_SERIALIZER_PARITY_EN
                par       <= ^data_in;
`else
                word_done <= (WIDTH == 1);
`endif
            end else begin
                unique case (state)
                    IDLE: begin
                        ser_out   <= IDLE_LEVEL;
                        ser_valid <= 1'b0;
                    end
                    SHIFT: begin
                        if (!last_bit) begin
                            shreg   <= shreg << 1;
                            cnt     <= cnt + 1'b1;
                            ser_out <= shreg[WIDTH-2];
`ifndef BIT_SERIALIZER_PARITY_EN
                            word_done <= (cnt == LAST - 1'b1);
`endif
                        end else begin
`ifdef BIT_SERIALIZER_PARITY_EN
                            state     <= PARITY;
                            shreg     <= shreg << 1;
                            ser_out   <= par;
                            word_done <= 1'b1;
`else
                            state     <= IDLE;
                            shreg     <= '0;
                            cnt       <= '0;
                            ser_out   <= IDLE_LEVEL;
                            ser_valid <= 1'b0;
`endif
                        end
                    end
`ifdef BIT_SERIALIZER_PARITY_EN
                    PARITY: begin
                        state     <= IDLE;
                        shreg     <= '0;
                        cnt       <= '0;
                        ser_out   <= IDLE_LEVEL;
                        ser_valid <= 1'b0;
                    end
`endif
                    default: begin
                        state     <= IDLE;
                        ser_out   <= IDLE_LEVEL;
                        ser_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

    if ((1 << CNT_W) < WIDTH) begin : g_cnt_w_check
        $error("bit_serializer: CNT_W too small for WIDTH");
    end

    cnt_range_a: assert property (
        @(posedge clk) disable iff (!rst) cnt <= LAST
    ) else $error("bit_serializer: counter beyond WIDTH-1");

endmodule

// File: tb/tb_bit_serializer.sv
// Scoreboard bench for bit_serializer: accepted words expand to expected bit
// queues; a negedge monitor pops and checks every cycle.
module tb_bit_serializer;
    localparam int   W       = 4;
    localparam logic IDLE_LV = 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
    localparam bit   PAR     = 1'b1;
`else
    localparam bit   PAR     = 1'b0;
`endif

    typedef struct packed {
        logic b;
        logic last;
    } exp_t;

    logic         clk        = 1'b0;
    logic         rst        = 1'b1;
    logic [W-1:0] data_in    = '0;
    logic         load_valid = 1'b0;
    logic         load_ready;
    logic         ser_out;
    logic         ser_valid;
    logic         word_done;

    int   total = 0;
    int   bad   = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    bit_serializer #(
        .WIDTH(W),
        .CNT_W(3),
        .IDLE_LEVEL(IDLE_LV)
    ) dut (
        .clk(clk),
        .rst(rst),
        .data_in(data_in),
        .load_valid(load_valid),
        .load_ready(load_ready),
        .ser_out(ser_out),
        .ser_valid(ser_valid),
        .word_done(word_done)
    );

    task automatic check(input string name, input logic got, input logic exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%b exp=%b t=%0t", name, got, exp, $time);
        end
    endtask

    // Reference: a word is WIDTH bits MSB first, plus its even parity if enabled.
    function automatic void push_word(input logic [W-1:0] d);
        exp_t e;
        for (int i = W - 1; i >= 0; i--) begin
            e.b    = d[i];
            e.last = (i == 0) && !PAR;
            q.push_back(e);
        end
        if (PAR) begin
            e.b    = ^d;
            e.last = 1'b1;
            q.push_back(e);
        end
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (q.size() == 0) begin
            check("idle_valid", ser_valid, 1'b0);
            check("idle_out", ser_out, IDLE_LV);
            check("idle_done", word_done, 1'b0);
            check("idle_ready", load_ready, 1'b1);
        end else begin
            e = q.pop_front();
            check("ser_valid", ser_valid, 1'b1);
            check("ser_out", ser_out, e.b);
            check("word_done", word_done, e.last);
            check("load_ready", load_ready, e.last);
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 of the accepting edge.
    task automatic send(input logic [W-1:0] d);
        int n = 0;
        load_valid = 1'b1;
        data_in    = d;
        @(negedge clk);
        while (!load_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (!load_ready) begin
            bad++;
            $display("FAIL handshake_timeout got=%b exp=1", load_ready);
        end
        @(posedge clk);
        if (load_ready) push_word(d);
        #1;
        load_valid = 1'b0;
        data_in    = W'($urandom);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out"}, ser_out, IDLE_LV);
        check({tag, "_valid"}, ser_valid, 1'b0);
        check({tag, "_done"}, word_done, 1'b0);
        check({tag, "_ready"}, load_ready, 1'b1);
    endtask

    initial begin : driver
        int n;
        #1 rst = 1'b0;
        #1 check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        idle(1);

        send(4'b1011);
        idle(W + 2);

        send(4'b1011);
        send(4'b0110);
        idle(W + 2);

        send(4'b1011);
        idle(W + 3);
        send(4'b0011);
        idle(W + 2);

        send(4'b1101);
        @(posedge clk);
        #2 rst = 1'b0;
        q.delete();
        #1 check_reset_outputs("midword_reset");
        @(posedge clk);
        #2 rst = 1'b1;
        idle(1);
        send(4'b0101);
        idle(W + 2);

        send(4'b1001);
        send(4'b1111);
        send(4'b0000);
        idle(W + 2);

        repeat (150) begin
            idle($urandom_range(0, 2));
            send(W'($urandom));
        end

        n = 0;
        while (q.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain left=%0d exp=0", q.size());
        end
        idle(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
